// File: rtl/div_unit_pkg.sv
// Shared encodings for the RV64M divide unit: funct3 select codes, FSM states, iteration counts.
package div_unit_pkg;

    localparam logic [2:0] DivQ  = 3'b100;
    localparam logic [2:0] DivQU = 3'b101;
    localparam logic [2:0] DivR  = 3'b110;
    localparam logic [2:0] DivRU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Counter start values: steps run while counting down to zero inclusive.
    localparam int ITER_D = 63;
    localparam int ITER_W = 31;

endpackage

// File: rtl/div_operand_prep.sv
// Combinational operand conditioning: W-form extension, magnitudes, result signs and
// special-case detection (divide by zero, signed overflow). Zero latency, no flow control.
module div_operand_prep
    import div_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            signed_i,
    input  logic            div32_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] a_ext_o,
    output logic [XLEN-1:0] mag_a_o,
    output logic [XLEN-1:0] mag_b_o,
    output logic            q_neg_o,
    output logic            r_neg_o,
    output logic            div_zero_o,
    output logic            overflow_o
);

    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] min_val;
    logic            a_neg;
    logic            b_neg;

    always_comb begin
        if (div32_i) begin
            a_ext_o = {{(XLEN-32){signed_i & dividend_i[31]}}, dividend_i[31:0]};
            b_ext   = {{(XLEN-32){signed_i & divisor_i[31]}}, divisor_i[31:0]};
            min_val = {{(XLEN-31){1'b1}}, 31'b0};
        end else begin
            a_ext_o = dividend_i;
            b_ext   = divisor_i;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg      = signed_i & a_ext_o[XLEN-1];
        b_neg      = signed_i & b_ext[XLEN-1];
        mag_a_o    = a_neg ? -a_ext_o : a_ext_o;
        mag_b_o    = b_neg ? -b_ext : b_ext;
        q_neg_o    = a_neg ^ b_neg;
        r_neg_o    = a_neg;
        div_zero_o = (b_ext == '0);
        overflow_o = signed_i & (a_ext_o == min_val) & (b_ext == '1);
    end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring RV64M divide/remainder: 66 cycles (34 for W-forms), 1 cycle for
// special cases when DIV_FASTPATH_EN is defined. Result held in DONE until out_ready.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      div_sel,
    input  logic            div32,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    div_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] q_q, r_q, d_q, aext_q, result_q;
    logic            op_q, rem_q, w_q, qneg_q, rneg_q, dz_q, ovf_q, fix2_q;

    logic [XLEN-1:0] p_aext, p_mag_a, p_mag_b;
    logic            p_qneg, p_rneg, p_dz, p_ovf;
    logic [XLEN:0]   r_sh_d;
    logic            ge_d;

    div_operand_prep #(.XLEN(XLEN)) u_prep (
        .signed_i   (~div_sel[0]),
        .div32_i    (div32),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .a_ext_o    (p_aext),
        .mag_a_o    (p_mag_a),
        .mag_b_o    (p_mag_b),
        .q_neg_o    (p_qneg),
        .r_neg_o    (p_rneg),
        .div_zero_o (p_dz),
        .overflow_o (p_ovf)
    );

    function automatic logic [XLEN-1:0] pick(input logic op, input logic rem, input logic w,
                                             input logic dz, input logic ovf,
                                             input logic [XLEN-1:0] aext,
                                             input logic [XLEN-1:0] q,
                                             input logic [XLEN-1:0] r);
        logic [XLEN-1:0] v;
        if (!op)       v = '0;
        else if (dz)   v = rem ? aext : '1;
        else if (ovf)  v = rem ? '0 : aext;
        else           v = rem ? r : q;
        if (w) v = {{(XLEN-32){v[31]}}, v[31:0]};
        return v;
    endfunction

    assign r_sh_d = {r_q, q_q[XLEN-1]};
    assign ge_d   = (r_sh_d >= {1'b0, d_q});

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            q_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            aext_q   <= '0;
            result_q <= '0;
            op_q     <= 1'b0;
            rem_q    <= 1'b0;
            w_q      <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            fix2_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            fix2_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= div_sel[2];
                        rem_q  <= div_sel[1];
                        w_q    <= div32;
                        aext_q <= p_aext;
                        qneg_q <= p_qneg;
                        rneg_q <= p_rneg;
                        dz_q   <= p_dz;
                        ovf_q  <= p_ovf;
                        d_q    <= p_mag_b;
                        r_q    <= '0;
                        fix2_q <= 1'b0;
                        // W-forms park the 32-bit magnitude at the top so 32 shifts finish it.
                        q_q    <= div32 ? {p_mag_a[31:0], {(XLEN-32){1'b0}}} : p_mag_a;
                        cnt_q  <= div32 ? CW'(ITER_W) : CW'(XLEN-1);
`ifdef DIV_FASTPATH_EN
                        if (div_sel[2] && (p_dz || p_ovf)) begin
                            result_q <= pick(1'b1, div_sel[1], div32, p_dz, p_ovf, p_aext, '0, '0);
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    q_q <= {q_q[XLEN-2:0], ge_d};
                    r_q <= ge_d ? XLEN'(r_sh_d - {1'b0, d_q}) : r_sh_d[XLEN-1:0];
                    if (cnt_q == '0) state_q <= FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                FIX: begin
                    // Sign correction and result selection are split over two edges.
                    if (!fix2_q) begin
                        q_q    <= qneg_q ? -q_q : q_q;
                        r_q    <= rneg_q ? -r_q : r_q;
                        fix2_q <= 1'b1;
                    end else begin
                        result_q <= pick(op_q, rem_q, w_q, dz_q, ovf_q, aext_q, q_q, r_q);
                        fix2_q   <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
